// File: rtl/bridge_arbiter_pkg.sv
// Shared types and constants for the two-master Bridge bus arbiter.
package bridge_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int   CNT_W  = 3;
    localparam int   DATA_W = 32;
    localparam logic M0     = 1'b0;
    localparam logic M1     = 1'b1;

endpackage

// File: rtl/bridge_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last time. Grant is one-hot (or zero when idle).
module rr_arbiter2
    import bridge_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == M1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Shares the Bridge data bus between the CPU MEM stage (master 0) and a
// secondary master, one access at a time, with a fixed read latency.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              cpu_clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_stall,
    output logic [DATA_W-1:0] Bus_addr,
    output logic              Bus_wen,
    output logic [DATA_W-1:0] Bus_wdata,
    input  logic [DATA_W-1:0] Bus_rdata
);

    state_t             state_reg;
    logic               last_grant_reg;
    logic               owner_reg;
    logic               wen_reg;
    logic               first_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;

    logic [1:0]         req_vec;
    logic [1:0]         grant;
    logic               sel_owner;
    logic               sel_wen;
    logic [DATA_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               access;
    logic               done;
    logic [1:0]         ack_vec;
    logic [DATA_W-1:0]  rdata_vec [2];

    assign req_vec = {m1_req, m0_req};

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign sel_owner = grant[1] ? M1 : M0;
    assign sel_wen   = grant[1] ? m1_wen   : m0_wen;
    assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;

    // Writes complete in their single ACCESS cycle; reads wait RD_LAT more.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= M1;
            owner_reg      <= M0;
            wen_reg        <= 1'b0;
            first_reg      <= 1'b0;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_reg <= sel_owner;
                        wen_reg   <= sel_wen;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        first_reg <= 1'b1;
                        cnt_reg   <= sel_wen ? '0 : CNT_W'(RD_LAT);
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    first_reg <= 1'b0;
                    if (cnt_reg == '0) begin
                        last_grant_reg <= owner_reg;
                        state_reg      <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign access    = (state_reg == ST_ACCESS);
    assign done      = access && (cnt_reg == '0);
    assign Bus_addr  = access ? addr_reg  : '0;
    assign Bus_wdata = access ? wdata_reg : '0;
    assign Bus_wen   = access && first_reg && wen_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign ack_vec[gi]   = done && (owner_reg == 1'(gi));
        assign rdata_vec[gi] = (ack_vec[gi] && !wen_reg) ? Bus_rdata : '0;
    end

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_rdata = rdata_vec[0];
    assign m1_rdata = rdata_vec[1];
    assign m0_stall = m0_req && !m0_ack;
    assign m1_stall = m1_req && !m1_ack;

endmodule
